// File: rtl/irq_sequencer.sv
// 6502 interrupt/reset entry sequencer: stacks PCH, PCL and P, then loads PC from a vector.
// The single IRQ line is widened to N_IRQ prioritised channels, each with its own vector.
module irq_sequencer #(
    parameter int unsigned N_IRQ        = 1,
    parameter logic [15:0] VEC_NMI      = 16'hFFFA,
    parameter logic [15:0] VEC_RST      = 16'hFFFC,
    parameter logic [15:0] VEC_IRQ      = 16'hFFFE,
    parameter logic [15:0] VEC_EXT_BASE = 16'hFFE0,
    parameter logic [7:0]  STACK_PAGE   = 8'h01,
    localparam int unsigned ID_W        = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ins_boundary,
    input  logic             brk,
    input  logic [N_IRQ-1:0] irq,
    input  logic             nmi,
    input  logic             i_flag,
    input  logic [15:0]      pc_in,
    input  logic [7:0]       p_in,
    input  logic [7:0]       sp_in,
    input  logic [7:0]       rdata,
    output logic [15:0]      addr,
    output logic [7:0]       wdata,
    output logic             we,
    output logic             busy,
    output logic             take,
    output logic             sp_dec,
    output logic [15:0]      pc_out,
    output logic             pc_load,
    output logic             set_i,
    output logic [1:0]       cause,
    output logic [ID_W-1:0]  irq_id
);

    typedef enum logic [2:0] {
        StIdle,
        StPushH,
        StPushL,
        StPushP,
        StVecL,
        StVecH
    } state_e;

    typedef enum logic [1:0] {
        CauseRst = 2'd0,
        CauseNmi = 2'd1,
        CauseIrq = 2'd2,
        CauseBrk = 2'd3
    } cause_e;

    state_e          state_q;
    cause_e          cause_q;
    logic [ID_W-1:0] irq_id_q;
    logic            nmi_prev_q;
    logic            nmi_pend_q;
    logic [15:0]     pc_q;
    logic [7:0]      p_q;
    logic [15:0]     vec_q;
    logic [7:0]      vec_lo_q;

    logic            nmi_edge;
    logic            irq_req;
    logic            accept;
    logic [ID_W-1:0] irq_sel;
    logic [15:0]     irq_vec;
    cause_e          acc_cause;
    logic [15:0]     acc_vec;
    logic [ID_W-1:0] acc_id;
    logic [15:0]     stack_addr;

    assign nmi_edge   = nmi & ~nmi_prev_q;
    assign irq_req    = (|irq) & ~i_flag;
    assign stack_addr = {STACK_PAGE, sp_in};
    assign accept     = ~reset & (state_q == StIdle) & ins_boundary & (nmi_pend_q | irq_req | brk);

    // Lowest-numbered active channel wins.
    always_comb begin
        irq_sel = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (irq[i]) begin
                irq_sel = ID_W'(i);
            end
        end
    end

    always_comb begin
        if (irq_sel == '0) begin
            irq_vec = VEC_IRQ;
        end else begin
            irq_vec = VEC_EXT_BASE + ((16'(irq_sel) - 16'd1) << 1);
        end
    end

    always_comb begin
        acc_cause = CauseBrk;
        acc_vec   = VEC_IRQ;
        acc_id    = '0;
        if (nmi_pend_q) begin
            acc_cause = CauseNmi;
            acc_vec   = VEC_NMI;
        end else if (irq_req) begin
            acc_cause = CauseIrq;
            acc_vec   = irq_vec;
            acc_id    = irq_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StVecL;
            cause_q    <= CauseRst;
            irq_id_q   <= '0;
            nmi_pend_q <= 1'b0;
            nmi_prev_q <= nmi;
            vec_q      <= VEC_RST;
            pc_q       <= '0;
            p_q        <= '0;
            vec_lo_q   <= '0;
        end else begin
            nmi_prev_q <= nmi;
            // An edge coinciding with the NMI being taken is already serviced.
            if (accept && (acc_cause == CauseNmi)) begin
                nmi_pend_q <= 1'b0;
            end else if (nmi_edge) begin
                nmi_pend_q <= 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q  <= StPushH;
                        cause_q  <= acc_cause;
                        irq_id_q <= acc_id;
                        pc_q     <= pc_in;
                        p_q      <= p_in;
                        vec_q    <= acc_vec;
                    end
                end
                StPushH: state_q <= StPushL;
                StPushL: state_q <= StPushP;
                StPushP: state_q <= StVecL;
                StVecL: begin
                    vec_lo_q <= rdata;
                    state_q  <= StVecH;
                end
                StVecH:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        addr    = '0;
        wdata   = '0;
        we      = 1'b0;
        busy    = 1'b0;
        take    = 1'b0;
        sp_dec  = 1'b0;
        pc_out  = '0;
        pc_load = 1'b0;
        set_i   = 1'b0;
        if (reset) begin
            busy = 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    busy = accept;
                    take = accept;
                end
                StPushH: begin
                    busy   = 1'b1;
                    addr   = stack_addr;
                    wdata  = pc_q[15:8];
                    we     = 1'b1;
                    sp_dec = 1'b1;
                end
                StPushL: begin
                    busy   = 1'b1;
                    addr   = stack_addr;
                    wdata  = pc_q[7:0];
                    we     = 1'b1;
                    sp_dec = 1'b1;
                end
                StPushP: begin
                    busy   = 1'b1;
                    addr   = stack_addr;
                    // Bit 5 always reads as 1; B is set only for a software BRK.
                    wdata  = {p_q[7:6], 1'b1, (cause_q == CauseBrk), p_q[3:0]};
                    we     = 1'b1;
                    sp_dec = 1'b1;
                end
                StVecL: begin
                    busy = 1'b1;
                    addr = vec_q;
                end
                StVecH: begin
                    busy    = 1'b1;
                    addr    = vec_q + 16'd1;
                    pc_out  = {rdata, vec_lo_q};
                    pc_load = 1'b1;
                    set_i   = 1'b1;
                end
                default: busy = 1'b0;
            endcase
        end
    end

    assign cause  = cause_q;
    assign irq_id = reset ? '0 : irq_id_q;

    // Bus writes and PC loads only ever occur inside a busy sequence.
    assert property (@(posedge clk) disable iff (reset) we |-> (busy && sp_dec));
    assert property (@(posedge clk) disable iff (reset) pc_load |-> (set_i && busy));
    assert property (@(posedge clk) disable iff (reset) take |-> (busy && state_q == StIdle));

endmodule
